// File: rtl/seu_share_ctrl.sv
// seu_share_ctrl: round-robin arbiter that shares one sign-magnitude to
// two's-complement extension unit between NUM_REQ requesters.
// Each accepted request drives the operand and enable for SETTLE_CYC cycles.
// The controller then captures the unit's result and returns it tagged with
// the requester id. Enable is dropped for at least one cycle between
// conversions, so every conversion starts on a fresh rising edge of enable.
// Optional build macro: SEU_NEGZERO_FLAG_EN adds the res_negzero output.
module seu_share_ctrl #(
    parameter int NUM_REQ    = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*9-1:0]       req_nr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic [8:0]                 seu_nr,
    output logic                       seu_en,
    input  logic [15:0]                seu_result,
    output logic                       res_valid,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
`ifdef SEU_NEGZERO_FLAG_EN
    output logic                       res_negzero,
`endif
    output logic [15:0]                res_data
);

    localparam int          IDW      = $clog2(NUM_REQ);
    localparam int unsigned NREQ     = NUM_REQ;
    localparam logic [3:0]  CNT_INIT = 4'(SETTLE_CYC - 1);

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic [8:0]         seu_nr_q, seu_nr_d;
    logic               seu_en_q, seu_en_d;
    logic               res_valid_q, res_valid_d;
    logic [IDW-1:0]     res_id_q, res_id_d;
    logic [15:0]        res_data_q, res_data_d;
`ifdef SEU_NEGZERO_FLAG_EN
    logic               negzero_q, negzero_d;
`endif

    logic               found;
    logic [IDW-1:0]     win;
    logic [8:0]         win_nr;
    logic [IDW-1:0]     win_next;

    // Round-robin search: first set request at or above the pointer, wrapping
    always_comb begin
        int unsigned idx;
        int unsigned nxt;
        logic [IDW-1:0] sel;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        sel   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            sel = IDW'(idx);
            if (!found && req[sel]) begin
                found = 1'b1;
                win   = sel;
            end
        end
        win_nr   = req_nr[9*win +: 9];
        nxt      = (32'(win) + 1) % NREQ;
        win_next = IDW'(nxt);
    end

    // Next-state and registered outputs for the IDLE/DRIVE controller
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        busy_d      = busy_q;
        seu_nr_d    = seu_nr_q;
        seu_en_d    = seu_en_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
`ifdef SEU_NEGZERO_FLAG_EN
        negzero_d   = negzero_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d[win] = 1'b1;
                    seu_nr_d   = win_nr;
                    seu_en_d   = 1'b1;
                    res_id_d   = win;
                    ptr_d      = win_next;
                    cnt_d      = CNT_INIT;
                    busy_d     = 1'b1;
                    state_d    = DRIVE;
`ifdef SEU_NEGZERO_FLAG_EN
                    negzero_d  = (win_nr == 9'h100);
`endif
                end
            end
            DRIVE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_data_d  = seu_result;
                    res_valid_d = 1'b1;
                    seu_en_d    = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; async reset aborts any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            seu_nr_q    <= '0;
            seu_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
`ifdef SEU_NEGZERO_FLAG_EN
            negzero_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            seu_nr_q    <= seu_nr_d;
            seu_en_q    <= seu_en_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
`ifdef SEU_NEGZERO_FLAG_EN
            negzero_q   <= negzero_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign seu_nr    = seu_nr_q;
    assign seu_en    = seu_en_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
`ifdef SEU_NEGZERO_FLAG_EN
    assign res_negzero = negzero_q;
`endif

endmodule

// File: tb/tb_seu_share_ctrl.sv
// Directed bench for seu_share_ctrl: dut_a uses SETTLE_CYC=1 and dut_b uses
// SETTLE_CYC=3. A behavioural extension-unit stub drives seu_result.
module tb_seu_share_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [3:0]  req_a, gnt_a, req_b, gnt_b;
    logic [35:0] req_nr_a, req_nr_b;
    logic        busy_a, seu_en_a, res_valid_a, busy_b, seu_en_b, res_valid_b;
    logic [8:0]  seu_nr_a, seu_nr_b;
    logic [15:0] seu_result_a, res_data_a, seu_result_b, res_data_b;
    logic [1:0]  res_id_a, res_id_b;
`ifdef SEU_NEGZERO_FLAG_EN
    logic        negzero_a, negzero_b;
`endif

    // Extension unit stub: sign-magnitude to 16-bit two's complement
    function automatic logic [15:0] ext(input logic [8:0] v);
        if (v[8]) return {8'hFF, ~v[7:0]} + 16'd1;
        return {8'h00, v[7:0]};
    endfunction

    assign seu_result_a = seu_en_a ? ext(seu_nr_a) : 16'h0000;
    assign seu_result_b = seu_en_b ? ext(seu_nr_b) : 16'h0000;

    seu_share_ctrl #(.NUM_REQ(4), .SETTLE_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .req_nr(req_nr_a), .gnt(gnt_a),
        .busy(busy_a), .seu_nr(seu_nr_a), .seu_en(seu_en_a),
        .seu_result(seu_result_a), .res_valid(res_valid_a), .res_id(res_id_a),
`ifdef SEU_NEGZERO_FLAG_EN
        .res_negzero(negzero_a),
`endif
        .res_data(res_data_a)
    );

    seu_share_ctrl #(.NUM_REQ(4), .SETTLE_CYC(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .req_nr(req_nr_b), .gnt(gnt_b),
        .busy(busy_b), .seu_nr(seu_nr_b), .seu_en(seu_en_b),
        .seu_result(seu_result_b), .res_valid(res_valid_b), .res_id(res_id_b),
`ifdef SEU_NEGZERO_FLAG_EN
        .res_negzero(negzero_b),
`endif
        .res_data(res_data_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        req_a    = '0;
        req_b    = '0;
        req_nr_a = '0;
        req_nr_b = '0;
        step();
        step();

        // Reset state
        chk("rst_gnt",    32'(gnt_a), 32'h0);
        chk("rst_busy",   32'(busy_a), 32'h0);
        chk("rst_seu_nr", 32'(seu_nr_a), 32'h0);
        chk("rst_seu_en", 32'(seu_en_a), 32'h0);
        chk("rst_valid",  32'(res_valid_a), 32'h0);
        chk("rst_id",     32'(res_id_a), 32'h0);
        chk("rst_data",   32'(res_data_a), 32'h0);
        rst_n = 1'b1;

        // Test 1: single positive operand
        req_a = 4'b0001;
        req_nr_a[8:0] = 9'h005;
        step();
        chk("t1_gnt",    32'(gnt_a), 32'h1);
        chk("t1_busy",   32'(busy_a), 32'h1);
        chk("t1_en",     32'(seu_en_a), 32'h1);
        chk("t1_nr",     32'(seu_nr_a), 32'h005);
        chk("t1_valid0", 32'(res_valid_a), 32'h0);
        req_a = '0;
        step();
        chk("t1_valid",  32'(res_valid_a), 32'h1);
        chk("t1_data",   32'(res_data_a), 32'h0005);
        chk("t1_id",     32'(res_id_a), 32'h0);
        chk("t1_en_off", 32'(seu_en_a), 32'h0);
        chk("t1_busy0",  32'(busy_a), 32'h0);
        chk("t1_gnt0",   32'(gnt_a), 32'h0);
        step();
        chk("t1_pulse",  32'(res_valid_a), 32'h0);
        chk("t1_hold",   32'(res_data_a), 32'h0005);

        // Test 2: negative operands
        req_a = 4'b0100;
        req_nr_a[26:18] = 9'h105;
        step();
        chk("t2_gnt2",  32'(gnt_a), 32'h4);
        chk("t2_nr2",   32'(seu_nr_a), 32'h105);
        req_a = '0;
        step();
        chk("t2_val2",  32'(res_valid_a), 32'h1);
        chk("t2_data2", 32'(res_data_a), 32'hFFFB);
        chk("t2_id2",   32'(res_id_a), 32'h2);
        req_a = 4'b0010;
        req_nr_a[17:9] = 9'h1FF;
        step();
        chk("t2_gnt1",  32'(gnt_a), 32'h2);
        req_a = '0;
        step();
        chk("t2_data1", 32'(res_data_a), 32'hFF01);
        chk("t2_id1",   32'(res_id_a), 32'h1);

        // Test 3: all requesters held from reset, round-robin order
        rst_n = 1'b0;
        req_a = 4'b1111;
        req_nr_a = {9'h004, 9'h003, 9'h002, 9'h001};
        step();
        chk("t3_rst_gnt", 32'(gnt_a), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_gnt",  32'(gnt_a), 32'(1) << (i % 4));
            chk("t3_en",   32'(seu_en_a), 32'h1);
            step();
            chk("t3_valid", 32'(res_valid_a), 32'h1);
            chk("t3_data",  32'(res_data_a), 32'((i % 4) + 1));
            chk("t3_id",    32'(res_id_a), 32'(i % 4));
            chk("t3_gap",   32'(seu_en_a), 32'h0);
        end
        req_a = '0;

        // Test 4: SETTLE_CYC=3, request arriving during DRIVE
        req_b = 4'b0001;
        req_nr_b[8:0] = 9'h07F;
        step();
        chk("t4_gnt0",  32'(gnt_b), 32'h1);
        chk("t4_en1",   32'(seu_en_b), 32'h1);
        req_b = 4'b1000;
        req_nr_b[35:27] = 9'h003;
        step();
        chk("t4_gnt_drv", 32'(gnt_b), 32'h0);
        chk("t4_en2",   32'(seu_en_b), 32'h1);
        chk("t4_busy",  32'(busy_b), 32'h1);
        chk("t4_v2",    32'(res_valid_b), 32'h0);
        step();
        chk("t4_en3",   32'(seu_en_b), 32'h1);
        chk("t4_v3",    32'(res_valid_b), 32'h0);
        step();
        chk("t4_valid", 32'(res_valid_b), 32'h1);
        chk("t4_data",  32'(res_data_b), 32'h007F);
        chk("t4_en_off", 32'(seu_en_b), 32'h0);
        chk("t4_gnt_cap", 32'(gnt_b), 32'h0);
        step();
        chk("t4_gnt3",  32'(gnt_b), 32'h8);
        chk("t4_id3",   32'(res_id_b), 32'h3);
        chk("t4_v_off", 32'(res_valid_b), 32'h0);
        req_b = '0;
        step();
        step();
        step();
        chk("t4_valid3", 32'(res_valid_b), 32'h1);
        chk("t4_data3",  32'(res_data_b), 32'h0003);
        step();
        chk("t4_hold_d", 32'(res_data_b), 32'h0003);
        chk("t4_hold_i", 32'(res_id_b), 32'h3);

        // Test 5: reset mid-DRIVE aborts, pointer returns to 0
        req_b = 4'b0100;
        req_nr_b[26:18] = 9'h10A;
        step();
        chk("t5_gnt",   32'(gnt_b), 32'h4);
        chk("t5_en",    32'(seu_en_b), 32'h1);
        req_b = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_en0",   32'(seu_en_b), 32'h0);
        chk("t5_busy0", 32'(busy_b), 32'h0);
        chk("t5_val0",  32'(res_valid_b), 32'h0);
        chk("t5_nr0",   32'(seu_nr_b), 32'h0);
        chk("t5_data0", 32'(res_data_b), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_noval", 32'(res_valid_b), 32'h0);
            chk("t5_noen",  32'(seu_en_b), 32'h0);
        end
        req_b = 4'b1010;
        req_nr_b[17:9]  = 9'h011;
        req_nr_b[35:27] = 9'h133;
        step();
        chk("t5_ptr0",  32'(gnt_b), 32'h2);
        req_b = '0;
        step();
        step();
        step();
        chk("t5_valid", 32'(res_valid_b), 32'h1);
        chk("t5_data",  32'(res_data_b), 32'h0011);

        // Test 6: negative zero and positive zero
        req_a = 4'b0001;
        req_nr_a[8:0] = 9'h100;
        step();
        chk("t6_gnt",   32'(gnt_a), 32'h1);
        req_a = '0;
        step();
        chk("t6_valid", 32'(res_valid_a), 32'h1);
        chk("t6_nz_data", 32'(res_data_a), 32'h0000);
`ifdef SEU_NEGZERO_FLAG_EN
        chk("t6_nz1",   32'(negzero_a), 32'h1);
`endif
        req_a = 4'b0001;
        req_nr_a[8:0] = 9'h000;
        step();
        chk("t6_gnt2",  32'(gnt_a), 32'h1);
        req_a = '0;
        step();
        chk("t6_valid2", 32'(res_valid_a), 32'h1);
        chk("t6_z_data", 32'(res_data_a), 32'h0000);
`ifdef SEU_NEGZERO_FLAG_EN
        chk("t6_nz0",   32'(negzero_a), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
